spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/demoscene_spi_pkg.sv | 15 +
 rtl/spi_tick_gen.sv | 31 +++
 rtl/spi_master.sv | 112 +++++++++++
 3 files changed

// File: rtl/demoscene_spi_pkg.sv
// Shared SPI constants and state encoding.
// Also imported by the demoscene SPI responder.
package demoscene_spi_pkg;

    localparam int unsigned SPI_WIDTH_DEFAULT = 8;
    localparam int unsigned SPI_CLK_DIV_MIN   = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StHold  = 2'd2,
        StGap   = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// SCLK half-period tick generator: counts 0..CLK_DIV-1 and pulses tick_o on the last count.
// clear_i restarts the count so a new transfer's first tick lands exactly CLK_DIV cycles later.
module spi_tick_gen
    import demoscene_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    // Values below the legal minimum are clamped rather than producing a degenerate divider.
    localparam int unsigned Div = (CLK_DIV < SPI_CLK_DIV_MIN) ? SPI_CLK_DIV_MIN : CLK_DIV;

    logic [7:0] cnt_q;

    assign tick_o = (cnt_q == 8'(Div - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: MSB-first WIDTH-bit transfers, optional SSEL hold between words,
// and a two-half-period gap before SSEL rises and the block returns to idle.
module spi_master
    import demoscene_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned WIDTH   = SPI_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_hold_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             busy_o,
    output logic             sclk_o,
    output logic             ssel_o,
    output logic             mosi_o,
    input  logic             miso_i
);

    localparam int unsigned HalfW = $clog2(2 * WIDTH) + 1;
    localparam logic [HalfW-1:0] LastHalf = HalfW'(2 * WIDTH - 1);

    spi_state_e       state_q;
    logic [WIDTH-1:0] tx_shift_q;
    logic [WIDTH-1:0] rx_shift_q;
    logic [WIDTH-1:0] rx_data_q;
    logic [HalfW-1:0] half_q;
    logic             hold_q;
    logic             rx_valid_q;
    logic             sclk_q;
    logic             ssel_q;
    logic             mosi_q;
    logic             tick;
    logic             accept;

    assign tx_ready_o = (state_q == StIdle) || (state_q == StHold);
    assign accept     = tx_valid_i && tx_ready_o;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (accept),
        .tick_o  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            half_q     <= '0;
            hold_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            ssel_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (accept) begin
                state_q    <= StShift;
                tx_shift_q <= tx_data_i;
                hold_q     <= tx_hold_i;
                half_q     <= '0;
                sclk_q     <= 1'b0;
                ssel_q     <= 1'b0;
                mosi_q     <= tx_data_i[WIDTH-1];
            end else if (tick) begin
                unique case (state_q)
                    StShift: begin
                        sclk_q <= ~sclk_q;
                        half_q <= half_q + 1'b1;
                        // Even half-periods end in a rising SCLK edge, odd ones in a falling edge.
                        if (!half_q[0]) begin
                            rx_shift_q <= {rx_shift_q[WIDTH-2:0], miso_i};
                        end else if (half_q == LastHalf) begin
                            rx_data_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= hold_q ? StHold : StGap;
                        end else begin
                            tx_shift_q <= tx_shift_q << 1;
                            mosi_q     <= tx_shift_q[WIDTH-2];
                        end
                    end
                    StGap: begin
                        // First tick releases SSEL, second tick returns to idle.
                        if (!ssel_q) begin
                            ssel_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q != StIdle);
    assign sclk_o     = sclk_q;
    assign ssel_o     = ssel_q;
    assign mosi_o     = mosi_q;

endmodule
